pattern_search_engine: RTL and testbench
========================================

Name: pattern_search_engine

Overview:
- Hardware responder for the program-3 request/done handshake.
- On a `start` pulse it reads a 32-byte message string and a 5-bit pattern from data memory. It then counts pattern occurrences three ways and writes the three 8-bit results back to data memory.
- It then raises `done`.
- It sits beside the data memory as a second memory master, driven by the same `start`/`done` handshake the program-3 test harness uses.

Parameters:
- STR_BASE, 0, address of first string byte (byte 0 = MSB end of the bit stream).
- STR_LEN, 32, number of string bytes; legal range 2..32.
- PAT_ADDR, 32, address of pattern byte.
- RES_ADDR, 33, first result address; results occupy RES_ADDR, RES_ADDR+1, RES_ADDR+2.
- AW, 8, memory address width.

Ports:
- clk, in, 1: single clock, all state on rising edge.
- reset, in, 1: asynchronous, active-low reset.
- start, in, 1: one-cycle request pulse; sampled only in IDLE.
- done, out, 1: level acknowledge; high from job completion until the next accepted start.
- mem_addr, out, AW: memory address.
- mem_rd_data, in, 8: memory read data; combinational (valid in the same cycle as mem_addr).
- mem_wr_en, out, 1: write strobe; the memory writes on the rising edge.
- mem_wr_data, out, 8: write data.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE.
  - done=0, mem_wr_en=0, mem_addr=0, mem_wr_data=0.
  - All counters, the pattern register and prev_byte cleared.
- Reset mid-job: abort immediately with no further writes; results already written stay in memory.
- States: IDLE -> LOAD_PAT -> SCAN -> WR_CTB -> WR_CTO -> WR_CTS -> FIN.
- IDLE: start=1 at a rising edge -> LOAD_PAT. That same edge also does the following:
  - done<=0.
  - ctb, cto and cts cleared.
  - idx cleared.
- LOAD_PAT (1 cycle): mem_addr=PAT_ADDR; pat<=mem_rd_data. Next state is SCAN.
- SCAN (STR_LEN cycles): mem_addr=STR_BASE+idx, and cur=mem_rd_data. Each cycle:
  - Form w = {prev_byte, cur} (16 bits).
  - In-byte windows: w[7:3], w[6:2], w[5:1], w[4:0].
  - Crossing windows: w[11:7], w[10:6], w[9:5], w[8:4]. These are counted only when idx>=1.
  - A window matches iff window == pat[4:0] and pat[7:5] == 0. A nonzero pat[7:5] means no match ever, so all results are 0.
  - ctb += number of in-byte matches (0..4).
  - cto += 1 if any in-byte window matches.
  - cts += in-byte matches + crossing matches.
  - prev_byte<=cur; idx++.
  - After idx=STR_LEN-1 the next state is WR_CTB.
- WR_CTB, WR_CTO, WR_CTS: one cycle each, with mem_wr_en=1.
  - Addresses are RES_ADDR, RES_ADDR+1, RES_ADDR+2 respectively.
  - Data is ctb, cto, cts respectively.
- FIN: done<=1, then IDLE.
- Latency: done is high after the 37th rising edge following the edge that accepted start, for STR_LEN=32. In general the latency is STR_LEN+5.
- Widths and ranges: counters are 8 bits.
  - ctb max 4*STR_LEN (128).
  - cto max STR_LEN (32).
  - cts max 8*STR_LEN-4 (252).
  - No overflow is possible in the legal range.
- start outside IDLE is ignored (no restart, no effect on counts).
- start in the same cycle that done rises is ignored; it is sampled again in IDLE.
- mem_wr_en is high only in the WR_* states. Outside LOAD_PAT, SCAN and WR_*, mem_addr holds 0.
- Back-to-back jobs must give identical results, with no leakage of prev_byte or counters between jobs.

Test Plan:
- All 32 bytes 0xC1, pat 0x07, pulse start -> done after 37 cycles; mem[33]=0, mem[34]=0, mem[35]=31.
- All bytes 0x00, pat 0x00 -> mem[33]=128, mem[34]=32, mem[35]=252.
- All bytes 0x55, pat 0x15 -> mem[33]=64, mem[34]=32, mem[35]=126.
- All bytes 0x00, pat 0xA0 (upper bits set) -> 0, 0, 0 written; done still asserted on schedule.
- Reset mid-job: drop reset low at SCAN idx=10 -> done=0, mem_wr_en=0 immediately; mem[33..35] untouched. Then release reset and start again -> correct results.
- start pulsed again during SCAN and during FIN -> ignored; results match the single-run values and exactly three writes are observed per job.

Source files
------------

// File: rtl/pattern_search_engine.sv
// Pattern search responder: reads a byte string and a 5-bit pattern from
// memory, counts matches three ways and writes the counts back.
//
// Ports:
//   clk          - rising-edge clock
//   reset        - asynchronous active-low reset
//   start        - one-cycle job request, sampled only in IDLE
//   done         - high from job completion until the next accepted start
//   mem_addr     - memory address (0 when not accessing memory)
//   mem_rd_data  - combinational read data for mem_addr
//   mem_wr_en    - write strobe, high only while writing results
//   mem_wr_data  - write data
module pattern_search_engine #(
  parameter int STR_BASE = 0,
  parameter int STR_LEN  = 32,
  parameter int PAT_ADDR = 32,
  parameter int RES_ADDR = 33,
  parameter int AW       = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          done,
  output logic [AW-1:0] mem_addr,
  input  logic [7:0]    mem_rd_data,
  output logic          mem_wr_en,
  output logic [7:0]    mem_wr_data
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_PAT,
    SCAN,
    WR_CTB,
    WR_CTO,
    WR_CTS,
    FIN
  } state_t;

  state_t state;
  state_t state_nx;

  logic [7:0]  pat;
  // Only the low nibble of the previous byte reaches any window.
  logic [3:0]  prev_low;
  logic [7:0]  ctb;
  logic [7:0]  cto;
  logic [7:0]  cts;
  logic [5:0]  idx;

  logic [11:0] w;
  logic        pat_ok;
  logic [3:0]  in_m;
  logic [3:0]  x_m;
  logic [2:0]  in_hits;
  logic [2:0]  x_hits;
  logic        last;

  always_comb begin
    w      = {prev_low, mem_rd_data};
    pat_ok = (pat[7:5] == 3'd0);
    in_m[3] = pat_ok && (w[7:3]  == pat[4:0]);
    in_m[2] = pat_ok && (w[6:2]  == pat[4:0]);
    in_m[1] = pat_ok && (w[5:1]  == pat[4:0]);
    in_m[0] = pat_ok && (w[4:0]  == pat[4:0]);
    // Crossing windows need a real previous byte.
    x_m[3]  = pat_ok && (idx != 6'd0) && (w[11:7] == pat[4:0]);
    x_m[2]  = pat_ok && (idx != 6'd0) && (w[10:6] == pat[4:0]);
    x_m[1]  = pat_ok && (idx != 6'd0) && (w[9:5]  == pat[4:0]);
    x_m[0]  = pat_ok && (idx != 6'd0) && (w[8:4]  == pat[4:0]);
    in_hits = 3'(in_m[3]) + 3'(in_m[2])
            + 3'(in_m[1]) + 3'(in_m[0]);
    x_hits  = 3'(x_m[3]) + 3'(x_m[2])
            + 3'(x_m[1]) + 3'(x_m[0]);
    last    = (idx == 6'(STR_LEN - 1));
  end

  always_comb begin
    state_nx    = state;
    mem_addr    = '0;
    mem_wr_en   = 1'b0;
    mem_wr_data = 8'd0;
    unique case (state)
      IDLE: begin
        if (start) state_nx = LOAD_PAT;
      end
      LOAD_PAT: begin
        mem_addr = AW'(PAT_ADDR);
        state_nx = SCAN;
      end
      SCAN: begin
        mem_addr = AW'(STR_BASE) + AW'(idx);
        if (last) state_nx = WR_CTB;
      end
      WR_CTB: begin
        mem_addr    = AW'(RES_ADDR);
        mem_wr_en   = 1'b1;
        mem_wr_data = ctb;
        state_nx    = WR_CTO;
      end
      WR_CTO: begin
        mem_addr    = AW'(RES_ADDR + 1);
        mem_wr_en   = 1'b1;
        mem_wr_data = cto;
        state_nx    = WR_CTS;
      end
      WR_CTS: begin
        mem_addr    = AW'(RES_ADDR + 2);
        mem_wr_en   = 1'b1;
        mem_wr_data = cts;
        state_nx    = FIN;
      end
      FIN: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      done     <= 1'b0;
      pat      <= 8'd0;
      prev_low <= 4'd0;
      ctb      <= 8'd0;
      cto      <= 8'd0;
      cts      <= 8'd0;
      idx      <= 6'd0;
    end else begin
      state <= state_nx;
      unique case (state)
        IDLE: begin
          if (start) begin
            done     <= 1'b0;
            ctb      <= 8'd0;
            cto      <= 8'd0;
            cts      <= 8'd0;
            idx      <= 6'd0;
            prev_low <= 4'd0;
          end
        end
        LOAD_PAT: begin
          pat <= mem_rd_data;
        end
        SCAN: begin
          ctb      <= ctb + 8'(in_hits);
          cto      <= cto + 8'(in_m != 4'd0);
          cts      <= cts + 8'(in_hits) + 8'(x_hits);
          prev_low <= mem_rd_data[3:0];
          idx      <= idx + 6'd1;
        end
        FIN: begin
          done <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_search_engine.sv
// Bench for pattern_search_engine: directed and random jobs checked
// against a bit-stream occurrence model.
module tb_pattern_search_engine;

  localparam int LEN = 32;

  logic       clk;
  logic       reset;
  logic       start;
  logic       done;
  logic [7:0] mem_addr;
  logic [7:0] mem_rd_data;
  logic       mem_wr_en;
  logic [7:0] mem_wr_data;

  logic [7:0] mem [256];
  int         wr_count;
  int         checks;
  int         failures;

  pattern_search_engine dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .done        (done),
    .mem_addr    (mem_addr),
    .mem_rd_data (mem_rd_data),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_data (mem_wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rd_data = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_wr_en) begin
      mem[mem_addr] <= mem_wr_data;
      wr_count = wr_count + 1;
    end
  end

  task automatic check(input string tag,
                       input int got,
                       input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Counts every 5-bit occurrence in the MSB-first bit stream.
  task automatic model(output int ctb,
                       output int cto,
                       output int cts);
    logic [7:0] p;
    int         hit [LEN];
    p   = mem[32];
    ctb = 0;
    cto = 0;
    cts = 0;
    for (int i = 0; i < LEN; i++) hit[i] = 0;
    if (p[7:5] != 3'd0) return;
    for (int s = 0; s <= 8*LEN - 5; s++) begin
      int v;
      v = 0;
      for (int b = 0; b < 5; b++) begin
        int q;
        logic [7:0] by;
        q  = s + b;
        by = mem[q/8];
        v  = v*2 + int'(by[7 - q%8]);
      end
      if (v == int'(p[4:0])) begin
        cts++;
        if (s/8 == (s+4)/8) begin
          ctb++;
          hit[s/8] = 1;
        end
      end
    end
    for (int i = 0; i < LEN; i++) cto += hit[i];
  endtask

  task automatic fill(input logic [7:0] v,
                      input logic [7:0] p);
    for (int i = 0; i < LEN; i++) mem[i] = v;
    mem[32] = p;
  endtask

  task automatic run_job(input string tag,
                         input bit pulses);
    int cyc;
    int e_ctb;
    int e_cto;
    int e_cts;
    model(e_ctb, e_cto, e_cts);
    wr_count = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!done && cyc < 200) begin
      start = pulses && (cyc == 10 || cyc == 36);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check({tag, ".latency"}, cyc, LEN + 5);
    check({tag, ".writes"}, wr_count, 3);
    check({tag, ".ctb"}, int'(mem[33]), e_ctb);
    check({tag, ".cto"}, int'(mem[34]), e_cto);
    check({tag, ".cts"}, int'(mem[35]), e_cts);
    @(negedge clk);
    check({tag, ".idle_addr"}, int'(mem_addr), 0);
    check({tag, ".idle_done"}, int'(done), 1);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    wr_count = 0;
    start    = 1'b0;
    reset    = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'd0;
    repeat (2) @(negedge clk);
    check("rst.done", int'(done), 0);
    check("rst.wr_en", int'(mem_wr_en), 0);
    check("rst.addr", int'(mem_addr), 0);
    check("rst.wdata", int'(mem_wr_data), 0);
    reset = 1'b1;
    @(negedge clk);

    fill(8'hC1, 8'h07);
    run_job("c1", 1'b0);
    check("c1.cts_const", int'(mem[35]), 31);
    fill(8'h00, 8'h00);
    run_job("zero", 1'b0);
    check("zero.ctb_const", int'(mem[33]), 128);
    check("zero.cts_const", int'(mem[35]), 252);
    fill(8'h55, 8'h15);
    run_job("alt", 1'b1);
    check("alt.ctb_const", int'(mem[33]), 64);
    check("alt.cts_const", int'(mem[35]), 126);
    fill(8'h00, 8'hA0);
    run_job("upper", 1'b0);
    check("upper.cts_const", int'(mem[35]), 0);

    // Abort during SCAN at idx=10.
    fill(8'h00, 8'h00);
    mem[33] = 8'hEE;
    mem[34] = 8'hEE;
    mem[35] = 8'hEE;
    wr_count = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort.done", int'(done), 0);
    check("abort.wr_en", int'(mem_wr_en), 0);
    repeat (3) @(negedge clk);
    check("abort.writes", wr_count, 0);
    check("abort.m33", int'(mem[33]), 8'hEE);
    check("abort.m35", int'(mem[35]), 8'hEE);
    reset = 1'b1;
    @(negedge clk);
    run_job("after_abort", 1'b0);

    for (int j = 0; j < 10; j++) begin
      logic [7:0] p;
      int         alpha;
      alpha = $urandom_range(0, 2);
      for (int i = 0; i < LEN; i++) begin
        logic [7:0] r;
        r = 8'($urandom);
        if (alpha == 0) mem[i] = r;
        else if (alpha == 1) mem[i] = r & 8'h81;
        else mem[i] = (r[0]) ? 8'hFF : 8'h3C;
      end
      p = 8'($urandom_range(0, 31));
      if ($urandom_range(0, 7) == 0) p[7:5] = 3'($urandom_range(1, 7));
      mem[32] = p;
      run_job($sformatf("rnd%0d", j), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
